// File: rtl/bit_serializer_if.sv
// Handshake and serial-output bundle between a parallel word source and bit_serializer.
// The master drives load/din/en; the slave (the serializer) drives the registered outputs.
interface bit_serializer_if #(
  parameter int WIDTH = 8
) ();
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             load;
  logic [WIDTH-1:0] din;
  logic             en;
  logic             ready;
  logic             x;
  logic             x_valid;
  logic             done;
  logic [CNT_W-1:0] bit_cnt;

  modport master (
    output load, din, en,
    input  ready, x, x_valid, done, bit_cnt
  );

  modport slave (
    input  load, din, en,
    output ready, x, x_valid, done, bit_cnt
  );
endinterface

// File: rtl/bit_serializer.sv
// Parallel-in, serial-out frame generator feeding the sequence detector.
// Every output is a flop, so the detector input never sees a combinational glitch.
module bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  bit_serializer_if.slave  bus
);
  localparam int                CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] FULL  = CNT_W'(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             x_q, x_d;
  logic             x_valid_q, x_valid_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;

  // The head bit always sits at the end selected by MSB_FIRST; shifting moves the next one there.
  function automatic logic head_bit(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? v[WIDTH-1] : v[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? (v << 1) : (v >> 1);
  endfunction

  always_comb begin
    // NOTE: every _d starts from its _q so no path through the case can infer a latch.
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    x_d       = x_q;
    x_valid_d = x_valid_q;
    done_d    = done_q;
    ready_d   = ready_q;

    unique case (state_q)
      IDLE: begin
        if (bus.load) begin
          state_d   = SHIFT;
          shreg_d   = bus.din;
          x_d       = head_bit(bus.din);
          x_valid_d = 1'b1;
          bit_cnt_d = '0;
          done_d    = 1'b0;
          ready_d   = 1'b0;
        end
      end

      SHIFT: begin
        // en=0 leaves every _d at its _q, freezing the frame in place.
        if (bus.en) begin
          if (bit_cnt_q == LAST) begin
            state_d   = DONE;
            x_d       = 1'b0;
            x_valid_d = 1'b0;
            done_d    = 1'b1;
            bit_cnt_d = FULL;
          end else begin
            shreg_d   = advance(shreg_q);
            x_d       = head_bit(advance(shreg_q));
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end

      DONE: begin
        state_d   = IDLE;
        done_d    = 1'b0;
        ready_d   = 1'b1;
        bit_cnt_d = '0;
        shreg_d   = '0;
      end

      default: begin
        state_d   = IDLE;
        shreg_d   = '0;
        bit_cnt_d = '0;
        x_d       = 1'b0;
        x_valid_d = 1'b0;
        done_d    = 1'b0;
        ready_d   = 1'b1;
      end
    endcase
  end

  // Reset also clears the shift register so an aborted frame leaves no residue.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      x_q       <= 1'b0;
      x_valid_q <= 1'b0;
      done_q    <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so all flops update together from pre-edge values.
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      x_q       <= x_d;
      x_valid_q <= x_valid_d;
      done_q    <= done_d;
      ready_q   <= ready_d;
    end
  end

  assign bus.ready   = ready_q;
  assign bus.x       = x_q;
  assign bus.x_valid = x_valid_q;
  assign bus.done    = done_q;
  assign bus.bit_cnt = bit_cnt_q;
endmodule

// File: tb/tb_bit_serializer.sv
// Scoreboard bench for bit_serializer: stimulus queues the hand-computed bit stream,
// negedge monitors pop and compare whenever a DUT shows x_valid.
module tb_bit_serializer;
  typedef struct packed {
    logic       x;
    logic [3:0] cnt;
  } exp_t;

  logic clk;
  logic reset;

  bit_serializer_if #(.WIDTH(8)) m_if ();
  bit_serializer_if #(.WIDTH(8)) l_if ();

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk   (clk),
    .reset (reset),
    .bus   (m_if)
  );

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk   (clk),
    .reset (reset),
    .bus   (l_if)
  );

  int   tests_run    = 0;
  int   tests_failed = 0;
  exp_t m_q[$];
  exp_t l_q[$];
  exp_t m_e, l_e;
  int   m_done_seen = 0, l_done_seen = 0;
  int   m_done_exp  = 0, l_done_exp  = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitors: each valid bit must match the next queued expectation.
  always @(negedge clk) begin
    if (!reset && m_if.x_valid) begin
      if (m_q.size() == 0) check("msb_unexpected_bit", 32'(m_if.bit_cnt), 32'hFFFF);
      else begin
        m_e = m_q.pop_front();
        check("msb_x", 32'(m_if.x), 32'(m_e.x));
        check("msb_bit_cnt", 32'(m_if.bit_cnt), 32'(m_e.cnt));
      end
    end
    if (!reset && m_if.done) m_done_seen++;
  end

  always @(negedge clk) begin
    if (!reset && l_if.x_valid) begin
      if (l_q.size() == 0) check("lsb_unexpected_bit", 32'(l_if.bit_cnt), 32'hFFFF);
      else begin
        l_e = l_q.pop_front();
        check("lsb_x", 32'(l_if.x), 32'(l_e.x));
        check("lsb_bit_cnt", 32'(l_if.bit_cnt), 32'(l_e.cnt));
      end
    end
    if (!reset && l_if.done) l_done_seen++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic get_ready(input bit sel);
    return sel ? l_if.ready : m_if.ready;
  endfunction
  function automatic logic get_x(input bit sel);
    return sel ? l_if.x : m_if.x;
  endfunction
  function automatic logic get_xv(input bit sel);
    return sel ? l_if.x_valid : m_if.x_valid;
  endfunction
  function automatic logic get_done(input bit sel);
    return sel ? l_if.done : m_if.done;
  endfunction
  function automatic logic [3:0] get_cnt(input bit sel);
    return sel ? l_if.bit_cnt : m_if.bit_cnt;
  endfunction

  task automatic drive(input bit sel, input logic ld, input logic [7:0] d, input logic e);
    if (sel) begin
      l_if.load = ld; l_if.din = d; l_if.en = e;
    end else begin
      m_if.load = ld; m_if.din = d; m_if.en = e;
    end
  endtask

  task automatic check_idle(input string name, input bit sel);
    check({name, "_ready"},   32'(get_ready(sel)), 32'd1);
    check({name, "_x"},       32'(get_x(sel)),     32'd0);
    check({name, "_x_valid"}, 32'(get_xv(sel)),    32'd0);
    check({name, "_done"},    32'(get_done(sel)),  32'd0);
    check({name, "_bit_cnt"}, 32'(get_cnt(sel)),   32'd0);
  endtask

  // seq[7] is the first bit expected on x, seq[0] the last.
  task automatic push_frame(input bit sel, input logic [7:0] seq, input int stall_at,
                            input int stall_len);
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      for (int r = 0; r < ((i == stall_at) ? 1 + stall_len : 1); r++) begin
        e.x   = seq[7-i];
        e.cnt = 4'(i);
        if (sel) l_q.push_back(e);
        else m_q.push_back(e);
      end
    end
  endtask

  task automatic wait_ready(input bit sel);
    int n = 0;
    while (!get_ready(sel) && n < 50) begin
      tick();
      n++;
    end
    check("wait_ready", 32'(get_ready(sel)), 32'd1);
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] d, input logic [7:0] seq,
                            input int stall_at, input int stall_len);
    wait_ready(sel);
    push_frame(sel, seq, stall_at, stall_len);
    drive(sel, 1'b1, d, 1'b1);
    tick();
    drive(sel, 1'b0, ~d, 1'b1);
    check("accept_x_valid", 32'(get_xv(sel)), 32'd1);
    check("accept_ready", 32'(get_ready(sel)), 32'd0);
    for (int i = 0; i < 8; i++) begin
      if (i == stall_at) begin
        drive(sel, 1'b0, ~d, 1'b0);
        for (int s = 0; s < stall_len; s++) begin
          tick();
          check("stall_bit_cnt", 32'(get_cnt(sel)), 32'(i));
          check("stall_x", 32'(get_x(sel)), 32'(seq[7-i]));
        end
        drive(sel, 1'b0, ~d, 1'b1);
      end
      tick();
    end
    check("done_pulse", 32'(get_done(sel)), 32'd1);
    check("done_ready", 32'(get_ready(sel)), 32'd0);
    check("done_x_valid", 32'(get_xv(sel)), 32'd0);
    check("done_bit_cnt", 32'(get_cnt(sel)), 32'd8);
    if (sel) l_done_exp++;
    else m_done_exp++;
    tick();
    check_idle("after_done", sel);
  endtask

  initial begin
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    drive(1'b1, 1'b0, 8'h00, 1'b0);

    // Reset then idle
    reset = 1'b1;
    #15;
    check_idle("in_reset_msb", 1'b0);
    check_idle("in_reset_lsb", 1'b1);
    #5;
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      check_idle("idle", 1'b0);
    end

    // Basic MSB-first frame: A5 -> 1,0,1,0,0,1,0,1
    send_frame(1'b0, 8'hA5, 8'b1010_0101, 99, 0);

    // Stall of 3 cycles at bit 2
    send_frame(1'b0, 8'hA5, 8'b1010_0101, 2, 3);

    // Back-to-back with load held high; din change during SHIFT ignored
    wait_ready(1'b0);
    push_frame(1'b0, 8'b1111_1111, 99, 0);
    push_frame(1'b0, 8'b0000_0000, 99, 0);
    drive(1'b0, 1'b1, 8'hFF, 1'b1);
    tick();
    drive(1'b0, 1'b1, 8'h00, 1'b1);
    repeat (7) tick();
    check("b2b_busy_cnt", 32'(get_cnt(1'b0)), 32'd7);
    check("b2b_busy_ready", 32'(get_ready(1'b0)), 32'd0);
    tick();
    check("b2b_done1", 32'(get_done(1'b0)), 32'd1);
    tick();
    check("b2b_idle_ready", 32'(get_ready(1'b0)), 32'd1);
    check("b2b_idle_x_valid", 32'(get_xv(1'b0)), 32'd0);
    tick();
    check("b2b_accept2_x_valid", 32'(get_xv(1'b0)), 32'd1);
    check("b2b_accept2_cnt", 32'(get_cnt(1'b0)), 32'd0);
    drive(1'b0, 1'b0, 8'hFF, 1'b1);
    repeat (8) tick();
    check("b2b_done2", 32'(get_done(1'b0)), 32'd1);
    m_done_exp += 2;
    tick();
    check_idle("b2b_end", 1'b0);

    // LSB-first: 01 -> 1,0,0,0,0,0,0,0
    send_frame(1'b1, 8'h01, 8'b1000_0000, 99, 0);

    // Asynchronous reset during bit 4 of A5
    wait_ready(1'b0);
    begin
      exp_t e;
      logic [7:0] seq = 8'b1010_0101;
      for (int i = 0; i < 4; i++) begin
        e.x   = seq[7-i];
        e.cnt = 4'(i);
        m_q.push_back(e);
      end
    end
    drive(1'b0, 1'b1, 8'hA5, 1'b1);
    tick();
    drive(1'b0, 1'b0, 8'hA5, 1'b1);
    repeat (4) tick();
    check("pre_reset_cnt", 32'(get_cnt(1'b0)), 32'd4);
    #3;
    reset = 1'b1;
    #1;
    check_idle("async_reset", 1'b0);
    #2;
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check_idle("post_reset", 1'b0);
    end

    // New frame after reset: 3C -> 0,0,1,1,1,1,0,0
    send_frame(1'b0, 8'h3C, 8'b0011_1100, 99, 0);

    repeat (3) tick();
    check("msb_queue_drained", 32'(m_q.size()), 32'd0);
    check("lsb_queue_drained", 32'(l_q.size()), 32'd0);
    check("msb_done_count", 32'(m_done_seen), 32'(m_done_exp));
    check("lsb_done_count", 32'(l_done_seen), 32'(l_done_exp));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/bit_serializer.md
# bit_serializer

Upstream stage for the lab sequence detector. Loads a parallel WIDTH-bit word and shifts it out one bit per clock on `x`, qualified by `x_valid`, with a load/ready handshake and a one-cycle `done` pulse per frame. `x` connects directly to the detector's serial input. Every output is registered, so the detector sees a glitch-free bit on each rising edge.

## Interface
Parameters:
- WIDTH, 8, frame length in bits (2..32)
- MSB_FIRST, 1, 1 = din[WIDTH-1] sent first; 0 = din[0] sent first

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-high; one clock, reset is asynchronous and active-high
- load  input  1  request to start a frame; honoured only when `ready`=1
- din  input  WIDTH  frame data, sampled on the accepting edge
- en  input  1  shift enable; 0 freezes the frame in progress
- ready  output  1  block idle, will accept `load`
- x  output  1  serial data bit to detector
- x_valid  output  1  `x` carries a frame bit this cycle
- done  output  1  one-cycle pulse after the last bit of a frame
- bit_cnt  output  $clog2(WIDTH+1)  bits already sent in the current frame

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - ready=1, x=0, x_valid=0, done=0, bit_cnt=0.
  - load=1 at an edge: capture din into the shift register, go to SHIFT. The first bit appears on `x` after the same edge, with x_valid=1 and bit_cnt=0.
- SHIFT:
  - ready=0, x_valid=1.
  - `x` = the current head bit: MSB for MSB_FIRST=1, LSB otherwise.
  - Edge with en=1 and bit_cnt<WIDTH-1: advance to the next bit, bit_cnt+1.
  - Edge with en=1 and bit_cnt=WIDTH-1: go to DONE. Set x=0, x_valid=0, done=1, bit_cnt=WIDTH.
  - Edge with en=0: hold x, x_valid, bit_cnt and state unchanged.
- DONE:
  - Lasts exactly one cycle: done=1, ready=0.
  - Next edge returns to IDLE unconditionally, done=0, ready=1. `en` is ignored in DONE.
- `load` while ready=0 (SHIFT or DONE) is ignored. `din` changes outside the accepting edge have no effect.
- load=1 and en=0 at the accepting edge: the frame is still captured. SHIFT then holds bit 0 until en=1.
- Reset asserted in any state, including mid-frame:
  - Immediately forces IDLE, ready=1, x=0, x_valid=0, done=0, bit_cnt=0, and clears the shift register.
  - The partial frame is discarded. No `done` pulse is produced for it.
- bit_cnt never exceeds WIDTH and never wraps.

## Timing
- Reset values: ready=1, x=0, x_valid=0, done=0, bit_cnt=0, state=IDLE.
- With load accepted at edge E0 and en=1 throughout:
  - bit i is on `x` during cycle (E0+i, E0+i+1), for i=0..WIDTH-1.
  - done is high in cycle (E0+WIDTH, E0+WIDTH+1).
  - ready returns to 1 at E0+WIDTH+1.
- Frame period with back-to-back loads is WIDTH+2 cycles (load held high).
- Each en=0 cycle during SHIFT adds exactly one cycle to the frame.
- Latency from load to first bit valid: 1 edge.
- No combinational path from inputs to outputs.

## Test plan
- Reset then idle:
  - Stimulus: reset=1 for 20 ns, release, hold load=0 for 5 cycles.
  - Required: ready=1, x=0, x_valid=0, done=0, bit_cnt=0 throughout.
- Basic frame, WIDTH=8, MSB_FIRST=1:
  - Stimulus: load=1 with din=8'hA5 for one edge, en=1.
  - Required: x = 1,0,1,0,0,1,0,1 with x_valid=1 for 8 cycles; done=1 in cycle 9; ready=1 in cycle 10. Feeding `x` to the detector reproduces its expected `y`.
- Stall:
  - Stimulus: same frame as above with en=0 for 3 cycles after bit 2.
  - Required: x and bit_cnt=2 frozen for 3 cycles; frame completes 3 cycles late with bits unchanged.
- Busy load and back-to-back:
  - Stimulus: load=1 continuously, din=8'hFF then 8'h00 on the next accepting edge.
  - Required: din changes during SHIFT are ignored. Frames are separated by exactly one DONE cycle and one IDLE/accept edge, i.e. a 10-cycle period.
- LSB-first:
  - Stimulus: MSB_FIRST=0, din=8'h01.
  - Required: x = 1,0,0,0,0,0,0,0.
- Reset mid-frame:
  - Stimulus: assert reset asynchronously (not on an edge) during bit 4 of 8'hA5.
  - Required: outputs reach reset values before the next clock edge; no done pulse. A new load=1 with din=8'h3C after release sends 0,0,1,1,1,1,0,0.
